// File: rtl/ans_count_sender_pkg.sv
// Shared sizing and FSM encoding for the symbol-count sender.
// Used by the RTL and by the bench.
package ans_count_sender_pkg;

  localparam int CNT_WIDTH   = 8;
  localparam int SYM_COUNT   = 4;
  localparam int SYM_WIDTH   = 2;
  localparam int TOTAL_WIDTH = CNT_WIDTH + SYM_WIDTH;

  // The last index is SYM_COUNT-1, even when 2**SYM_WIDTH has spare codes.
  localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE
  } sender_state_t;

endpackage

// File: rtl/ans_count_sender.sv
// Streams a snapshotted frequency table, one word per 4-phase vld/rdy transfer,
// symbol 0 first, and accumulates the table total.
module ans_count_sender
  import ans_count_sender_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_WIDTH-1:0]   counts [SYM_COUNT],
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   out,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [TOTAL_WIDTH-1:0] total
);

  sender_state_t        state;
  sender_state_t        state_next;
  logic [CNT_WIDTH-1:0] snap [SYM_COUNT];
  logic [SYM_WIDTH-1:0] index;
  logic [SYM_WIDTH-1:0] index_inc;

  assign index_inc = index + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = DRIVE;
      DRIVE:   if (out_rdy)  state_next = RELEASE;
      RELEASE: if (!out_rdy) state_next = (index == LAST_IDX) ? IDLE : DRIVE;
      default:               state_next = IDLE;
    endcase
  end

  // The next word is registered onto out together with out_vld on entry to
  // DRIVE, so out is already stable in the first valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      index   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
      out_vld <= 1'b0;
      total   <= '0;
      for (int i = 0; i < SYM_COUNT; i++) snap[i] <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < SYM_COUNT; i++) snap[i] <= counts[i];
            index   <= '0;
            total   <= '0;
            busy    <= 1'b1;
            out     <= counts[0];
            out_vld <= 1'b1;
          end
        end
        DRIVE: begin
          if (out_rdy) begin
            total   <= total + TOTAL_WIDTH'(out);
            out_vld <= 1'b0;
          end
        end
        RELEASE: begin
          if (!out_rdy) begin
            if (index == LAST_IDX) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              index   <= index_inc;
              out     <= snap[index_inc];
              out_vld <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
